// File: rtl/pe_array_sequencer.sv
// Weight-load / X-stream sequencer for an NxN weight-stationary PE array.
// Optional busy-cycle counter output enabled by PE_SEQ_CYCLE_CNT_EN.
module pe_array_sequencer #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int LENW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LENW-1:0]   vec_len,
  input  logic              w_valid,
  input  logic [DW-1:0]     w_data,
  output logic              w_req,
  input  logic              x_valid,
  input  logic [N*DW-1:0]   x_data,
  output logic              x_req,
  output logic [N*N-1:0]    wt_load,
  output logic [DW-1:0]     wt_data,
  output logic [N-1:0]      pe_x_valid,
  output logic [N*DW-1:0]   pe_x_data,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PE_SEQ_CYCLE_CNT_EN
 ,output logic [31:0]       cycle_cnt
`endif
);

  localparam int NN  = N * N;
  localparam int WCW = $clog2(NN + 1);
  localparam int DRN = 2 * N + 2;
  localparam int DCW = $clog2(DRN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADW,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_xcnt;
  logic [WCW-1:0]  r_wcnt;
  logic [DCW-1:0]  r_dcnt;
  logic            r_w_req;
  logic            r_x_req;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [NN-1:0]   r_wt_load;
  logic [DW-1:0]   r_wt_data;

  logic w_accept;
  logic w_wbeat;
  logic w_xbeat;
  logic w_wlast;
  logic w_xlast;
  logic w_dlast;

  assign w_accept = (r_state == S_IDLE) & start
                  & (vec_len != '0);
  assign w_wbeat  = (r_state == S_LOADW) & w_valid;
  assign w_xbeat  = (r_state == S_STREAM) & x_valid;
  assign w_wlast  = (r_wcnt == WCW'(NN - 1));
  // r_len is never zero in STREAM, so the subtract cannot wrap
  assign w_xlast  = (r_xcnt == r_len - LENW'(1));
  assign w_dlast  = (r_dcnt == DCW'(DRN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_xcnt  <= '0;
      r_wcnt  <= '0;
      r_dcnt  <= '0;
      r_w_req <= 1'b0;
      r_x_req <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_LOADW;
            r_len   <= vec_len;
            r_wcnt  <= '0;
            r_xcnt  <= '0;
            r_dcnt  <= '0;
            r_w_req <= 1'b1;
            r_busy  <= 1'b1;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        S_LOADW: begin
          if (w_wbeat) begin
            if (w_wlast) begin
              r_state <= S_STREAM;
              r_wcnt  <= '0;
              r_w_req <= 1'b0;
              r_x_req <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + WCW'(1);
            end
          end
        end
        S_STREAM: begin
          if (w_xbeat) begin
            if (w_xlast) begin
              r_state <= S_DRAIN;
              r_xcnt  <= '0;
              r_x_req <= 1'b0;
            end else begin
              r_xcnt <= r_xcnt + LENW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_dlast) begin
            r_state <= S_DONE;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + DCW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wt_load <= '0;
      r_wt_data <= '0;
    end else begin
      for (int k = 0; k < NN; k++) begin
        r_wt_load[k] <= w_wbeat && (r_wcnt == WCW'(k));
      end
      if (w_wbeat) begin
        r_wt_data <= w_data;
      end
    end
  end

  // Row g sees its slice of each accepted X beat g+1 cycles later
  for (genvar g = 0; g < N; g++) begin : g_row
    logic [DW-1:0] r_d [g+1];
    logic [g:0]    r_v;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= '0;
        for (int i = 0; i <= g; i++) begin
          r_d[i] <= '0;
        end
      end else begin
        r_v[0] <= w_xbeat;
        r_d[0] <= w_xbeat ? x_data[g*DW +: DW] : '0;
        for (int i = 1; i <= g; i++) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
        end
      end
    end

    assign pe_x_valid[g]        = r_v[g];
    assign pe_x_data[g*DW +: DW] = r_d[g];
  end

`ifdef PE_SEQ_CYCLE_CNT_EN
  logic [31:0] r_ccnt;
  logic [31:0] r_cyc_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ccnt    <= '0;
      r_cyc_out <= '0;
    end else begin
      if (w_accept) begin
        r_ccnt    <= '0;
        r_cyc_out <= '0;
      end else if (r_busy) begin
        r_ccnt <= r_ccnt + 32'd1;
      end
      // include the final DRAIN cycle, which is still busy
      if (r_state == S_DRAIN && w_dlast) begin
        r_cyc_out <= r_ccnt + 32'd1;
      end
    end
  end

  assign cycle_cnt = r_cyc_out;
`endif

  assign w_req   = r_w_req;
  assign x_req   = r_x_req;
  assign wt_load = r_wt_load;
  assign wt_data = r_wt_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer with weight/skew scoreboards.
// Set PE_SEQ_CYCLE_CNT_EN to also check cycle_cnt.
module tb_pe_array_sequencer;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int LENW = 8;
  localparam int NN   = N * N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [LENW-1:0] vec_len = '0;
  logic            w_valid = 1'b0;
  logic [DW-1:0]   w_data = '0;
  logic            w_req;
  logic            x_valid = 1'b0;
  logic [N*DW-1:0] x_data = '0;
  logic            x_req;
  logic [NN-1:0]   wt_load;
  logic [DW-1:0]   wt_data;
  logic [N-1:0]    pe_x_valid;
  logic [N*DW-1:0] pe_x_data;
  logic            busy;
  logic            done;
  logic            err;
`ifdef PE_SEQ_CYCLE_CNT_EN
  logic [31:0]     cycle_cnt;
`endif

  pe_array_sequencer #(.N(N), .DW(DW), .LENW(LENW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_len    (vec_len),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .w_req      (w_req),
    .x_valid    (x_valid),
    .x_data     (x_data),
    .x_req      (x_req),
    .wt_load    (wt_load),
    .wt_data    (wt_data),
    .pe_x_valid (pe_x_valid),
    .pe_x_data  (pe_x_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef PE_SEQ_CYCLE_CNT_EN
   ,.cycle_cnt  (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_q;
  bit mon_en = 1'b0;
  logic [DW-1:0] mon_wd = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  typedef struct {
    int            t;
    int            k;
    logic [DW-1:0] d;
  } wexp_t;

  typedef struct {
    int            t;
    logic [DW-1:0] d;
  } xexp_t;

  wexp_t wq[$];
  xexp_t xq[N][$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h",
             tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [NN-1:0] ew;
    logic [DW-1:0] ed;
    logic          ev;
    if (mon_en) begin
      if (rst_q !== 1'b1) mon_wd = '0;
      ew = '0;
      ed = mon_wd;
      while (wq.size() > 0 && wq[0].t < cyc) void'(wq.pop_front());
      if (wq.size() > 0 && wq[0].t == cyc) begin
        ew[wq[0].k] = 1'b1;
        ed = wq[0].d;
        mon_wd = ed;
        void'(wq.pop_front());
      end
      chk("wt_load", 64'(wt_load), 64'(ew));
      chk("wt_data", 64'(wt_data), 64'(ed));
      for (int r = 0; r < N; r++) begin
        ev = 1'b0;
        while (xq[r].size() > 0 && xq[r][0].t < cyc)
          void'(xq[r].pop_front());
        if (xq[r].size() > 0 && xq[r][0].t == cyc) begin
          ev = 1'b1;
          chk($sformatf("pe_x_data[%0d]", r),
              64'(pe_x_data[r*DW +: DW]), 64'(xq[r][0].d));
          void'(xq[r].pop_front());
        end
        chk($sformatf("pe_x_valid[%0d]", r),
            64'(pe_x_valid[r]), 64'(ev));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, err, w_req, x_req, pe_x_valid}), 64'd0);
    chk({tag, "_wt"}, 64'({wt_load, wt_data}), 64'd0);
    chk({tag, "_pex"}, 64'(pe_x_data), 64'd0);
  endtask

  // Drives one full job; the first cycle is the IDLE start cycle.
  task automatic run_job(input int m, input int wgap,
                         input logic [15:0] xpat, input bit mid_start,
                         input logic [N*DW-1:0] xfirst,
                         output int t0, output int tdone);
    int beats;
    int xb;
    int i;
    nxt();
    rst_n   = 1'b1;
    start   = 1'b1;
    vec_len = LENW'(m);
    w_valid = 1'b1;
    x_valid = 1'b1;
    x_data  = {$urandom, $urandom};
    t0 = cyc;
    smp();
    chk("idle_busy", 64'(busy), 64'd0);
    nxt();
    start = 1'b0;
    beats = 0;
    i = 0;
    while (beats < NN) begin
      w_valid = ((i % (wgap + 1)) == 0);
      w_data  = DW'($urandom);
      x_valid = 1'b1;
      x_data  = {$urandom, $urandom};
      if (w_valid) begin
        wq.push_back('{cyc + 1, beats, w_data});
        beats++;
      end
      i++;
      smp();
      chk("loadw_ctl", 64'({busy, w_req, x_req, done}), 64'b1100);
      nxt();
    end
    xb = 0;
    i = 0;
    while (xb < m && i < 1000) begin
      x_valid = xpat[i % 16];
      x_data  = (xb == 0) ? xfirst : {$urandom, $urandom};
      w_valid = 1'b1;
      w_data  = DW'($urandom);
      start   = mid_start && (i == 0);
      vec_len = mid_start ? LENW'(5) : LENW'(m);
      if (x_valid) begin
        for (int r = 0; r < N; r++)
          xq[r].push_back('{cyc + r + 1, x_data[r*DW +: DW]});
        xb++;
      end
      i++;
      smp();
      chk("stream_ctl", 64'({busy, w_req, x_req, done}), 64'b1010);
      nxt();
    end
    start = 1'b0;
    for (int d = 0; d < 2 * N + 2; d++) begin
      x_valid = 1'b1;
      x_data  = {$urandom, $urandom};
      smp();
      chk("drain_ctl", 64'({busy, w_req, x_req, done}), 64'b1000);
      nxt();
    end
    smp();
    chk("done_ctl", 64'({busy, w_req, x_req, done, err}), 64'b00010);
    tdone = cyc;
`ifdef PE_SEQ_CYCLE_CNT_EN
    chk("cycle_cnt", 64'(cycle_cnt), 64'(tdone - t0 - 1));
`endif
    nxt();
    w_valid = 1'b0;
    x_valid = 1'b0;
    smp();
    chk("post_idle", 64'({busy, done, err, w_req, x_req}), 64'd0);
`ifdef PE_SEQ_CYCLE_CNT_EN
    chk("cycle_hold", 64'(cycle_cnt), 64'(tdone - t0 - 1));
`endif
  endtask

  initial begin
    int t0;
    int td;
    rst_n   = 1'b0;
    start   = 1'b1;
    vec_len = LENW'(3);
    w_valid = 1'b1;
    x_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nxt();
      mon_en = 1'b1;
      smp();
      chk_zero("in_reset");
    end

    // no-stall job released straight out of reset
    run_job(3, 0, 16'hFFFF, 1'b0, {$urandom, $urandom}, t0, td);
    chk("lat_basic", 64'(td - t0), 64'd30);

    // skew of a single beat, with stalled weight beats
    run_job(1, 2, 16'hFFFF, 1'b0,
            {16'd4, 16'd3, 16'd2, 16'd1}, t0, td);
    chk("lat_skew", 64'(td - t0), 64'd58);

    // X pattern 1,0,0,1,1
    run_job(3, 0, 16'h0019, 1'b0, {$urandom, $urandom}, t0, td);
    chk("lat_stall", 64'(td - t0), 64'd32);

    // zero-length job
    nxt();
    start   = 1'b1;
    vec_len = '0;
    nxt();
    start = 1'b0;
    smp();
    chk("err_pulse", 64'({err, busy}), 64'b10);
    nxt();
    smp();
    chk("err_clear", 64'({err, busy}), 64'b00);

    // start pulsed during STREAM is ignored
    run_job(2, 0, 16'hFFFF, 1'b1, {$urandom, $urandom}, t0, td);
    chk("lat_midstart", 64'(td - t0), 64'd29);

    // reset in the beat-7 cycle of LOADW
    nxt();
    start   = 1'b1;
    vec_len = LENW'(2);
    nxt();
    start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      w_valid = 1'b1;
      w_data  = DW'($urandom);
      if (b < 7) wq.push_back('{cyc + 1, b, w_data});
      else rst_n = 1'b0;
      smp();
      chk("abort_busy", 64'(busy), 64'd1);
      nxt();
    end
    rst_n   = 1'b1;
    w_valid = 1'b0;
    smp();
    chk_zero("after_abort");
    run_job(1, 0, 16'hFFFF, 1'b0, {$urandom, $urandom}, t0, td);
    chk("lat_restart", 64'(td - t0), 64'd28);

    // longest job
    run_job(255, 0, 16'hFFFF, 1'b0, {$urandom, $urandom}, t0, td);
    chk("lat_max", 64'(td - t0), 64'd282);

    nxt();
    smp();
    chk("wq_empty", 64'(wq.size()), 64'd0);
    for (int r = 0; r < N; r++)
      chk("xq_empty", 64'(xq[r].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_array_sequencer.md
PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, meaning the PE array dimension (N×N weight-stationary PEs).
REQ-002 SHALL have parameter DW, default 16, meaning the data and weight word width.
REQ-003 SHALL have parameter LENW, default 8, meaning the width of the vector-count field.
REQ-004 SHALL have port clk, in, 1, clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port rst_n, in, 1, reset, synchronous, active-low.
REQ-006 SHALL have port start, in, 1, job request, sampled in IDLE only.
REQ-007 SHALL have port vec_len, in, LENW, number of X vectors M in the job, sampled with start.
REQ-008 SHALL have ports w_valid (in, 1), w_data (in, DW) and w_req (out, 1), the weight-source handshake.
REQ-009 SHALL have ports x_valid (in, 1), x_data (in, N*DW, row r at bits [r*DW +: DW]) and x_req (out, 1), the X-source handshake.
REQ-010 SHALL have ports wt_load (out, N*N, one-hot PE weight enable) and wt_data (out, DW, broadcast weight).
REQ-011 SHALL have ports pe_x_valid (out, N, per-row data valid) and pe_x_data (out, N*DW, per-row skewed X).
REQ-012 SHALL have ports busy (out, 1), done (out, 1, pulse) and err (out, 1, pulse).

Function
REQ-013 SHALL implement FSM states IDLE, LOADW, STREAM, DRAIN and DONE.
REQ-014 In IDLE, start=1 with vec_len≠0 SHALL move to LOADW next cycle and latch vec_len; start=1 with vec_len=0 SHALL pulse err for one cycle and stay in IDLE.
REQ-015 LOADW: w_req=1; a beat is any cycle with w_valid=1; beat k (0..N*N-1) SHALL drive wt_load[k]=1 and wt_data=w_data one cycle later (registered); after beat N*N-1 the FSM SHALL move to STREAM.
REQ-016 wt_load SHALL be all-zero in every cycle that follows a non-beat cycle; wt_data SHALL hold its last value.
REQ-017 STREAM: x_req=1; on each x_valid beat, row r data and valid SHALL appear on pe_x_data/pe_x_valid[r] exactly r+1 cycles later (skew shift registers).
REQ-018 Stall cycles (x_valid=0 in STREAM) SHALL propagate as bubbles (pe_x_valid[r]=0) with no data loss.
REQ-019 After the M-th X beat the FSM SHALL move to DRAIN; DRAIN SHALL last exactly 2N+2 cycles with x_req=0 while the skew registers keep shifting and flush.
REQ-020 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-021 busy SHALL be 1 in LOADW, STREAM and DRAIN, and 0 in IDLE and DONE.
REQ-022 w_valid outside LOADW, x_valid outside STREAM, and start outside IDLE SHALL be ignored.
REQ-023 The beat counters SHALL be sized to N*N and 2^LENW-1 with no wrap-around; vec_len=2^LENW-1 SHALL be fully supported.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, including mid-job, and clear all counters and skew registers.
REQ-025 During and after reset, every output SHALL be 0 until the next accepted job.

Configuration
REQ-026 Macro PE_SEQ_CYCLE_CNT_EN defined: the block SHALL add output cycle_cnt (32 bits), count cycles with busy=1, and present that count with done, holding it until the next start accept.
REQ-027 Macro PE_SEQ_CYCLE_CNT_EN undefined: the block SHALL omit the cycle_cnt port and counter, with all other behaviour identical.

Verification
REQ-028 Reset: reset with N=4, start=1 and vec_len=3 held; release at T0, no stalls -> wt_load bits 0..15 pulse in T2..T17; STREAM T17..T19; done=1 at T30; cycle_cnt=29.
REQ-029 Skew: x_data rows {1,2,3,4} accepted at cycle t -> pe_x_valid[0]@t+1 with value 1, [1]@t+2 with value 2, [2]@t+3 with value 3, [3]@t+4 with value 4.
REQ-030 Stalls: x_valid pattern 1,0,0,1,1 with M=3 -> each row shows the same pattern with two-cycle bubbles preserved; done arrives 2 cycles later than the no-stall case.
REQ-031 Error/ignore: start with vec_len=0 -> err=1 for one cycle, busy stays 0; start pulsed during STREAM -> no effect.
REQ-032 Reset abort: rst_n=0 for one cycle in the middle of LOADW (beat 7) -> all outputs 0 next cycle; a new job afterwards restarts at wt_load[0].
